router_fsm: RTL and testbench
=============================

# router_fsm

Control state machine for the 1x3 router. Sequences the packet datapath register: decodes the header address, waits for the target FIFO, steers header/payload/parity loading, holds across FIFO-full stalls and triggers parity checking. Sits between the input port (`pkt_valid`, `data_in`), the three output FIFOs (empty/full/soft-reset) and the datapath register, whose state strobes it drives.

## Interface
- `CNT_W`, default 16: width of `pkt_cnt` (used only with `ROUTER_FSM_PKT_CNT_EN`).
- `clk` in 1: single clock, all state changes on rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `pkt_valid` in 1: input packet byte valid; deasserted on the parity byte.
- `data_in` in 2: header address bits `[1:0]`; 0/1/2 select an output, 3 is invalid.
- `fifo_full` in 1: selected FIFO full.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-FIFO empty.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-FIFO read-timeout soft reset.
- `parity_done` in 1: from the datapath register.
- `low_pkt_valid` in 1: from the datapath register.
- `write_enb_reg` out 1: FIFO write enable.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state` out 1 each: state strobes to the datapath register.
- `rst_int_reg` out 1: clears `low_pkt_valid` in the register.
- `busy` out 1: source must hold the current byte.
- `pkt_cnt` out `CNT_W`: completed-packet count.

## Operation
- States:
  - DECODE_ADDRESS (DA)
  - LOAD_FIRST_DATA (LFD)
  - LOAD_DATA (LD)
  - WAIT_TILL_EMPTY (WTE)
  - FIFO_FULL_STATE (FFS)
  - LOAD_AFTER_FULL (LAF)
  - LOAD_PARITY (LP)
  - CHECK_PARITY_ERROR (CPE)
- Address latch `addr_q[1:0]` loads `data_in` in DA when `pkt_valid && data_in != 3`. Within a packet, "empty" and "soft_reset" mean `fifo_empty_<addr_q>` and `soft_reset_<addr_q>`. In DA, empty is selected by the live `data_in`.
- Transitions, first match wins:
  - Any state: `soft_reset_<addr_q>` -> DA.
  - DA: `pkt_valid`, addr≠3, empty -> LFD; `pkt_valid`, addr≠3, not empty -> WTE; otherwise (including addr=3) stay.
  - WTE: empty -> LFD; else stay.
  - LFD: -> LD unconditionally.
  - LD: `fifo_full` -> FFS; `!pkt_valid` -> LP; else stay.
  - FFS: `!fifo_full` -> LAF; else stay.
  - LAF: `parity_done` -> DA; `low_pkt_valid` -> LP; else -> LD.
  - LP: -> CPE unconditionally.
  - CPE: `fifo_full` -> FFS; else -> DA.
- Outputs are Moore, decoded from the state register only:
  - `detect_add`=DA, `lfd_state`=LFD, `ld_state`=LD, `laf_state`=LAF, `full_state`=FFS, `rst_int_reg`=CPE.
  - `write_enb_reg` = LD|LP|LAF.
  - `busy` = LFD|FFS|LAF|LP|CPE|WTE (low only in DA and LD).

## Timing
- Reset, asynchronous on `resetn` low: state=DA, `addr_q`=0, `pkt_cnt`=0. Outputs during and after reset: `detect_add`=1, all others 0.
- Reset mid-packet aborts immediately. No partial-packet cleanup is done here.
- Outputs change one clock after the qualifying input edge. There is no combinational input-to-output path.
- Minimum packet (header, 1 payload, parity, FIFO empty, never full): DA→LFD→LD→LD→LP→CPE→DA. `busy` is high in LFD, LP and CPE.
- Soft reset asserted in the same cycle as any other transition condition wins.
- `soft_reset` of a non-selected FIFO is ignored.
- `fifo_full` in LD and `!pkt_valid` in the same cycle: FFS wins. Parity is loaded later through LAF.

## Configuration
- `ROUTER_FSM_PKT_CNT_EN` defined:
  - `pkt_cnt` increments by 1 on every CPE→DA or CPE→FFS exit.
  - Wraps modulo 2^`CNT_W`.
  - Soft reset does not increment.
- Not defined: `pkt_cnt` is tied to 0 and no counter flops exist. The port is always present.

## Structure
- `router_pkg` holds:
  - the state enum `router_state_e` (3-bit, binary encoded, DA=0);
  - the address constants `ADDR_0`/`ADDR_1`/`ADDR_2`/`ADDR_INV`.
- Single module with no sub-modules: state register, address latch, next-state logic, output decode and the optional counter.

## Test plan
- Reset, then `pkt_valid`=1, `data_in`=2'b01, `fifo_empty_1`=1 -> LFD, then LD. 3 payload bytes then `pkt_valid`=0 -> LP, then CPE (`rst_int_reg`=1 for one cycle), then DA. `pkt_cnt`=1 with the macro enabled.
- Header addr 0 with `fifo_empty_0`=0 for 5 cycles -> WTE with `busy`=1 held. Empty rises -> LFD next cycle.
- Header `data_in`=2'b11 held 4 cycles -> stays DA, `detect_add`=1, `busy`=0.
- `fifo_full`=1 in LD for 3 cycles -> FFS with `busy`=1. Full drops with `low_pkt_valid`=0 -> LAF then LD. Repeat with `low_pkt_valid`=1 -> LAF then LP.
- `soft_reset_2` during LD of an addr-2 packet -> DA next cycle. `soft_reset_0` in the same situation -> no effect.
- `resetn` low asynchronously mid-FFS -> outputs return to reset values before the next clock edge, `pkt_cnt`=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control FSM.
package router_pkg;

   typedef enum logic [2:0] {
      ST_DA  = 3'd0,
      ST_LFD = 3'd1,
      ST_LD  = 3'd2,
      ST_WTE = 3'd3,
      ST_FFS = 3'd4,
      ST_LAF = 3'd5,
      ST_LP  = 3'd6,
      ST_CPE = 3'd7
   } router_state_e;

   localparam logic [1:0] ADDR_0   = 2'd0;
   localparam logic [1:0] ADDR_1   = 2'd1;
   localparam logic [1:0] ADDR_2   = 2'd2;
   localparam logic [1:0] ADDR_INV = 2'd3;

   typedef struct packed {
      logic write_enb_reg;
      logic detect_add;
      logic lfd_state;
      logic ld_state;
      logic laf_state;
      logic full_state;
      logic rst_int_reg;
      logic busy;
   } router_out_t;

   // Moore output decode for a given state.
   function automatic router_out_t decode_outputs(router_state_e st);
      router_out_t o;
      o               = '0;
      o.detect_add    = (st == ST_DA);
      o.lfd_state     = (st == ST_LFD);
      o.ld_state      = (st == ST_LD);
      o.laf_state     = (st == ST_LAF);
      o.full_state    = (st == ST_FFS);
      o.rst_int_reg   = (st == ST_CPE);
      o.write_enb_reg = (st == ST_LD) || (st == ST_LP) || (st == ST_LAF);
      o.busy          = !((st == ST_DA) || (st == ST_LD));
      return o;
   endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: header decode, FIFO wait, load sequencing, full stalls, parity check.
// Optional completed-packet counter enabled by defining ROUTER_FSM_PKT_CNT_EN.
module router_fsm
   import router_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pkt_valid,
   input  logic [1:0]       data_in,
   input  logic             fifo_full,
   input  logic             fifo_empty_0,
   input  logic             fifo_empty_1,
   input  logic             fifo_empty_2,
   input  logic             soft_reset_0,
   input  logic             soft_reset_1,
   input  logic             soft_reset_2,
   input  logic             parity_done,
   input  logic             low_pkt_valid,
   output logic             write_enb_reg,
   output logic             detect_add,
   output logic             lfd_state,
   output logic             ld_state,
   output logic             laf_state,
   output logic             full_state,
   output logic             rst_int_reg,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_cnt
);

   router_state_e state_q, state_d;
   logic [1:0]    addr_q, addr_d;
   router_out_t   out_q, out_d;
   logic          empty_sel, srst_sel, hdr_empty, hdr_ok;

   // Per-FIFO status selected by the latched address; header path uses live data_in.
   always_comb begin
      empty_sel = 1'b0;
      srst_sel  = 1'b0;
      hdr_empty = 1'b0;
      case (addr_q)
         ADDR_0:  begin empty_sel = fifo_empty_0; srst_sel = soft_reset_0; end
         ADDR_1:  begin empty_sel = fifo_empty_1; srst_sel = soft_reset_1; end
         ADDR_2:  begin empty_sel = fifo_empty_2; srst_sel = soft_reset_2; end
         default: ;
      endcase
      case (data_in)
         ADDR_0:  hdr_empty = fifo_empty_0;
         ADDR_1:  hdr_empty = fifo_empty_1;
         ADDR_2:  hdr_empty = fifo_empty_2;
         default: ;
      endcase
   end

   assign hdr_ok = pkt_valid && (data_in != ADDR_INV);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_DA;
         addr_q  <= ADDR_0;
         out_q   <= decode_outputs(ST_DA);
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         out_q   <= out_d;
      end
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (state_q == ST_DA && hdr_ok) begin
         addr_d = data_in;
      end
      if (srst_sel) begin
         state_d = ST_DA;
      end else begin
         unique case (state_q)
            ST_DA:   if (hdr_ok) state_d = hdr_empty ? ST_LFD : ST_WTE;
            ST_WTE:  if (empty_sel) state_d = ST_LFD;
            ST_LFD:  state_d = ST_LD;
            ST_LD: begin
               if (fifo_full)       state_d = ST_FFS;
               else if (!pkt_valid) state_d = ST_LP;
            end
            ST_FFS:  if (!fifo_full) state_d = ST_LAF;
            ST_LAF: begin
               if (parity_done)        state_d = ST_DA;
               else if (low_pkt_valid) state_d = ST_LP;
               else                    state_d = ST_LD;
            end
            ST_LP:   state_d = ST_CPE;
            ST_CPE:  state_d = fifo_full ? ST_FFS : ST_DA;
            default: state_d = ST_DA;
         endcase
      end
      out_d = decode_outputs(state_d);
   end

   assign write_enb_reg = out_q.write_enb_reg;
   assign detect_add    = out_q.detect_add;
   assign lfd_state     = out_q.lfd_state;
   assign ld_state      = out_q.ld_state;
   assign laf_state     = out_q.laf_state;
   assign full_state    = out_q.full_state;
   assign rst_int_reg   = out_q.rst_int_reg;
   assign busy          = out_q.busy;

`ifdef ROUTER_FSM_PKT_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Every CPE exit completes a packet unless a soft reset forces the exit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (state_q == ST_CPE && !srst_sel) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign pkt_cnt = cnt_q;
`else
   assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: expected states are queued when stimulus is driven.
module tb_router_fsm;

   localparam int unsigned CNT_W = 16;

   typedef enum int {S_DA, S_LFD, S_LD, S_WTE, S_FFS, S_LAF, S_LP, S_CPE} st_e;

   typedef struct {
      logic       pv;
      logic [1:0] din;
      logic       full;
      logic [2:0] emp;
      logic [2:0] srst;
      logic       pd;
      logic       lpv;
      st_e        exp;
   } stim_t;

   typedef struct {
      st_e              st;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk, resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
   logic [1:0] data_in;
   logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic soft_reset_0, soft_reset_1, soft_reset_2;
   logic write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state;
   logic rst_int_reg, busy;
   logic [CNT_W-1:0] pkt_cnt;

   exp_t             exp_q[$];
   int               checks;
   int               errors;
   st_e              prev_m;
   logic [1:0]       addr_m;
   logic [CNT_W-1:0] cnt_m;

   wire [7:0] obs = {write_enb_reg, detect_add, lfd_state, ld_state,
                     laf_state, full_state, rst_int_reg, busy};

   router_fsm #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .write_enb_reg (write_enb_reg),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .busy          (busy),
      .pkt_cnt       (pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy}
   function automatic logic [7:0] exp_out(st_e s);
      case (s)
         S_DA:    return 8'b0100_0000;
         S_LFD:   return 8'b0010_0001;
         S_LD:    return 8'b1001_0000;
         S_WTE:   return 8'b0000_0001;
         S_FFS:   return 8'b0000_0101;
         S_LAF:   return 8'b1000_1001;
         S_LP:    return 8'b1000_0001;
         default: return 8'b0000_0011;
      endcase
   endfunction

   function automatic stim_t mk(logic pv, logic [1:0] din, logic full, logic [2:0] emp,
                                logic [2:0] srst, logic pd, logic lpv, st_e exp);
      stim_t s;
      s.pv = pv; s.din = din; s.full = full; s.emp = emp;
      s.srst = srst; s.pd = pd; s.lpv = lpv; s.exp = exp;
      return s;
   endfunction

   // Drive one cycle of inputs and queue the expected post-edge state and count.
   task automatic apply(input stim_t s);
      exp_t e;
      pkt_valid     = s.pv;
      data_in       = s.din;
      fifo_full     = s.full;
      {fifo_empty_2, fifo_empty_1, fifo_empty_0} = s.emp;
      {soft_reset_2, soft_reset_1, soft_reset_0} = s.srst;
      parity_done   = s.pd;
      low_pkt_valid = s.lpv;
      if (prev_m == S_CPE && !s.srst[addr_m]) cnt_m = cnt_m + CNT_W'(1);
      if (prev_m == S_DA && s.pv && s.din != 2'd3) addr_m = s.din;
      prev_m = s.exp;
      e.st = s.exp;
`ifdef ROUTER_FSM_PKT_CNT_EN
      e.cnt = cnt_m;
`else
      e.cnt = '0;
`endif
      exp_q.push_back(e);
   endtask

   task automatic idle_inputs();
      pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0; parity_done = 1'b0;
      low_pkt_valid = 1'b0;
      {fifo_empty_2, fifo_empty_1, fifo_empty_0} = 3'b111;
      {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle_inputs();
      prev_m = S_DA; addr_m = 2'd0; cnt_m = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs !== exp_out(S_DA)) begin
         errors++;
         $display("FAIL reset outputs: got %b expected %b", obs, exp_out(S_DA));
      end
      checks++;
      if (pkt_cnt !== '0) begin
         errors++;
         $display("FAIL reset pkt_cnt: got %0d expected 0", pkt_cnt);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_packet();
      stim_t seq[$];
      seq.push_back(mk(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, S_LFD));
      seq.push_back(mk(1, 2'd2, 0, 3'b010, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(1, 2'd3, 0, 3'b010, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(1, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_LP));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_CPE));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_DA));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_DA));
      foreach (seq[i]) begin
         exp_t e;
         apply(seq[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== exp_out(e.st)) begin
            errors++;
            $display("FAIL basic_packet step %0d outputs: got %b expected %b", i, obs, exp_out(e.st));
         end
         checks++;
         if (pkt_cnt !== e.cnt) begin
            errors++;
            $display("FAIL basic_packet step %0d pkt_cnt: got %0d expected %0d", i, pkt_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_wait_till_empty();
      stim_t seq[$];
      for (int k = 0; k < 5; k++) seq.push_back(mk(1, 2'd0, 0, 3'b110, 3'b000, 0, 0, S_WTE));
      seq.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD));
      seq.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP));
      seq.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE));
      seq.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
      foreach (seq[i]) begin
         exp_t e;
         apply(seq[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== exp_out(e.st)) begin
            errors++;
            $display("FAIL wait_till_empty step %0d outputs: got %b expected %b", i, obs, exp_out(e.st));
         end
         checks++;
         if (pkt_cnt !== e.cnt) begin
            errors++;
            $display("FAIL wait_till_empty step %0d pkt_cnt: got %0d expected %0d", i, pkt_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_invalid_addr();
      stim_t seq[$];
      for (int k = 0; k < 4; k++) seq.push_back(mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_DA));
      seq.push_back(mk(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
      foreach (seq[i]) begin
         exp_t e;
         apply(seq[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== exp_out(e.st)) begin
            errors++;
            $display("FAIL invalid_addr step %0d outputs: got %b expected %b", i, obs, exp_out(e.st));
         end
      end
   endtask

   task automatic test_fifo_full();
      stim_t seq[$];
      seq.push_back(mk(1, 2'd2, 0, 3'b100, 3'b000, 0, 0, S_LFD));
      seq.push_back(mk(1, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_LD));
      for (int k = 0; k < 3; k++) seq.push_back(mk(1, 2'd0, 1, 3'b100, 3'b000, 0, 0, S_FFS));
      seq.push_back(mk(1, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_LAF));
      seq.push_back(mk(1, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(0, 2'd0, 1, 3'b100, 3'b000, 0, 0, S_FFS));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 1, S_LAF));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 1, S_LP));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_CPE));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_DA));
      foreach (seq[i]) begin
         exp_t e;
         apply(seq[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== exp_out(e.st)) begin
            errors++;
            $display("FAIL fifo_full step %0d outputs: got %b expected %b", i, obs, exp_out(e.st));
         end
         checks++;
         if (pkt_cnt !== e.cnt) begin
            errors++;
            $display("FAIL fifo_full step %0d pkt_cnt: got %0d expected %0d", i, pkt_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_parity_paths();
      stim_t seq[$];
      seq.push_back(mk(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, S_LFD));
      seq.push_back(mk(1, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(1, 2'd0, 1, 3'b010, 3'b000, 0, 0, S_FFS));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_LAF));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 1, 1, S_DA));
      seq.push_back(mk(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, S_LFD));
      seq.push_back(mk(1, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_LP));
      seq.push_back(mk(0, 2'd0, 1, 3'b010, 3'b000, 0, 0, S_CPE));
      seq.push_back(mk(0, 2'd0, 1, 3'b010, 3'b000, 0, 0, S_FFS));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 0, 0, S_LAF));
      seq.push_back(mk(0, 2'd0, 0, 3'b010, 3'b000, 1, 0, S_DA));
      foreach (seq[i]) begin
         exp_t e;
         apply(seq[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== exp_out(e.st)) begin
            errors++;
            $display("FAIL parity_paths step %0d outputs: got %b expected %b", i, obs, exp_out(e.st));
         end
         checks++;
         if (pkt_cnt !== e.cnt) begin
            errors++;
            $display("FAIL parity_paths step %0d pkt_cnt: got %0d expected %0d", i, pkt_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_soft_reset();
      stim_t seq[$];
      seq.push_back(mk(1, 2'd2, 0, 3'b100, 3'b000, 0, 0, S_LFD));
      seq.push_back(mk(1, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(1, 2'd0, 0, 3'b100, 3'b001, 0, 0, S_LD));
      seq.push_back(mk(1, 2'd0, 1, 3'b100, 3'b100, 0, 0, S_DA));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_DA));
      seq.push_back(mk(1, 2'd2, 0, 3'b100, 3'b000, 0, 0, S_LFD));
      seq.push_back(mk(1, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_LP));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_CPE));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b100, 0, 0, S_DA));
      seq.push_back(mk(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, S_DA));
      foreach (seq[i]) begin
         exp_t e;
         apply(seq[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== exp_out(e.st)) begin
            errors++;
            $display("FAIL soft_reset step %0d outputs: got %b expected %b", i, obs, exp_out(e.st));
         end
         checks++;
         if (pkt_cnt !== e.cnt) begin
            errors++;
            $display("FAIL soft_reset step %0d pkt_cnt: got %0d expected %0d", i, pkt_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_async_reset();
      stim_t seq[$];
      exp_t  r;
      seq.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, S_LFD));
      seq.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, S_LD));
      seq.push_back(mk(1, 2'd0, 1, 3'b001, 3'b000, 0, 0, S_FFS));
      seq.push_back(mk(1, 2'd0, 1, 3'b001, 3'b000, 0, 0, S_FFS));
      foreach (seq[i]) begin
         exp_t e;
         apply(seq[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== exp_out(e.st)) begin
            errors++;
            $display("FAIL async_reset step %0d outputs: got %b expected %b", i, obs, exp_out(e.st));
         end
      end
      #2;
      resetn = 1'b0;
      prev_m = S_DA; addr_m = 2'd0; cnt_m = '0;
      r.st = S_DA; r.cnt = '0;
      exp_q.push_back(r);
      #1;
      r = exp_q.pop_front();
      checks++;
      if (obs !== exp_out(r.st)) begin
         errors++;
         $display("FAIL async_reset mid-cycle outputs: got %b expected %b", obs, exp_out(r.st));
      end
      checks++;
      if (pkt_cnt !== r.cnt) begin
         errors++;
         $display("FAIL async_reset mid-cycle pkt_cnt: got %0d expected %0d", pkt_cnt, r.cnt);
      end
      idle_inputs();
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      apply(mk(1, 2'd1, 0, 3'b000, 3'b000, 0, 0, S_WTE));
      @(posedge clk); #1;
      r = exp_q.pop_front();
      checks++;
      if (obs !== exp_out(r.st)) begin
         errors++;
         $display("FAIL async_reset restart outputs: got %b expected %b", obs, exp_out(r.st));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic_packet();
      test_wait_till_empty();
      test_invalid_addr();
      test_fifo_full();
      test_parity_paths();
      test_soft_reset();
      test_async_reset();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d leftover entries expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
